// File: rtl/nn_pkg.sv
// Shared fp16 definitions for the neuron activation datapath.
package nn_pkg;
    localparam int          FP16_W    = 16;
    localparam logic [14:0] FP16_ONE  = 15'h3C00;
    localparam logic [4:0]  CLAMP_EXP = 5'b01111;

    typedef logic [FP16_W-1:0] fp16_t;
endpackage

// File: rtl/act_unit_arbiter_if.sv
// Request/response bundle between the neuron requesters, the activation arbiter and writeback.
interface act_unit_arbiter_if
    import nn_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req_valid;
    fp16_t [NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0] req_ready;
    logic               out_valid;
    fp16_t              out_data;
    logic [ID_W-1:0]    out_id;
    logic               out_ready;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/act_unit_arbiter_clamp.sv
// Soft-step clamp: any magnitude >= 1.0 (including inf/NaN) becomes signed 1.0.
module fp16_clamp
    import nn_pkg::*;
(
    input  fp16_t i_data,
    output fp16_t o_data,
    output logic  o_clamped
);
    always_comb begin
        o_clamped = (i_data[14:10] >= CLAMP_EXP);
        o_data    = o_clamped ? {i_data[15], FP16_ONE} : i_data;
    end
endmodule

// File: rtl/act_unit_arbiter.sv
// Round-robin arbiter feeding a 2-stage stallable fp16 clamp pipe, with a clamp counter.
module act_unit_arbiter
    import nn_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    act_unit_arbiter_if.slave   bus,
    input  logic                cnt_clr,
    output logic [15:0]         clamp_cnt,
    output logic                busy
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic              r_s1_valid;
    fp16_t             r_s1_data;
    logic [ID_W-1:0]   r_s1_id;
    logic              r_out_valid;
    fp16_t             r_out_data;
    logic [ID_W-1:0]   r_out_id;
    logic              r_out_clamped;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [15:0]       r_clamp_cnt;

    logic               w_s2_adv;
    logic               w_accept_en;
    logic               w_found;
    logic               w_xfer;
    logic [ID_W-1:0]    w_gidx;
    logic [NUM_REQ-1:0] w_gnt;
    int                 w_cand;
    fp16_t              w_clamp_data;
    logic               w_clamped;

    assign w_s2_adv    = !r_out_valid | bus.out_ready;
    assign w_accept_en = !r_s1_valid | w_s2_adv;

    // First valid requester at or above rr_ptr, wrapping; no state kept between cycles.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_found && bus.req_valid[ID_W'(w_cand)]) begin
                w_found = 1'b1;
                w_gidx  = ID_W'(w_cand);
            end
        end
    end

    assign w_xfer = w_found & w_accept_en;

    always_comb begin
        w_gnt = '0;
        if (w_xfer) w_gnt[w_gidx] = 1'b1;
    end

    fp16_clamp u_clamp (
        .i_data   (r_s1_data),
        .o_data   (w_clamp_data),
        .o_clamped(w_clamped)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_data     <= '0;
            r_s1_id       <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_id      <= '0;
            r_out_clamped <= 1'b0;
            r_rr_ptr      <= '0;
            r_clamp_cnt   <= '0;
        end else begin
            if (w_accept_en) begin
                r_s1_valid <= w_xfer;
                if (w_xfer) begin
                    r_s1_data <= bus.req_data[w_gidx];
                    r_s1_id   <= w_gidx;
                    r_rr_ptr  <= (w_gidx == ID_W'(NUM_REQ-1)) ? '0 : w_gidx + 1'b1;
                end
            end
            if (w_s2_adv) begin
                r_out_valid   <= r_s1_valid;
                r_out_data    <= w_clamp_data;
                r_out_id      <= r_s1_id;
                r_out_clamped <= r_s1_valid & w_clamped;
            end
            // Clear wins over a same-cycle delivery.
            if (cnt_clr)
                r_clamp_cnt <= '0;
            else if (r_out_valid && bus.out_ready && r_out_clamped && r_clamp_cnt != 16'hFFFF)
                r_clamp_cnt <= r_clamp_cnt + 16'd1;
        end
    end

    assign bus.req_ready = w_gnt;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_id    = r_out_id;
    assign clamp_cnt     = r_clamp_cnt;
    assign busy          = r_s1_valid | r_out_valid;
endmodule

// File: tb/tb_act_unit_arbiter.sv
// Scoreboard bench for act_unit_arbiter: transfers push expected results, a monitor pops on delivery.
module tb_act_unit_arbiter;
    import nn_pkg::*;

    localparam int N = 4;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  id;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [15:0] clamp_cnt;
    logic        busy;

    act_unit_arbiter_if #(.NUM_REQ(N)) bus ();

    act_unit_arbiter #(.NUM_REQ(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .cnt_clr  (cnt_clr),
        .clamp_cnt(clamp_cnt),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    int          gnt_log[$];
    logic [15:0] rq_exp[N];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_d = '0;
    logic [1:0]  prev_id = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, want, $time);
        end
    endtask

    // Transfer capture and output scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    exp_q.push_back('{d: rq_exp[i], id: 2'(i)});
                    gnt_log.push_back(i);
                end
            end
            if (bus.out_valid) begin
                if (prev_stall) begin
                    chk("stall_data_stable", 32'(bus.out_data), 32'(prev_d));
                    chk("stall_id_stable", 32'(bus.out_id), 32'(prev_id));
                end
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 32'(bus.out_valid), 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("out_data", 32'(bus.out_data), 32'(e.d));
                        chk("out_id", 32'(bus.out_id), 32'(e.id));
                    end
                end
            end
            prev_stall = bus.out_valid & !bus.out_ready;
            prev_d     = bus.out_data;
            prev_id    = bus.out_id;
        end
    end

    task automatic send(input int id, input logic [15:0] d, input logic [15:0] e);
        int t;
        t = 0;
        bus.req_data[id]  = d;
        rq_exp[id]        = e;
        bus.req_valid[id] = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.req_ready[id] && t < 200);
        if (!bus.req_ready[id]) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 bus.req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((busy || exp_q.size() != 0) && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_busy", 32'(busy), 32'd0);
    endtask

    task automatic clr_cnt();
        cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
    endtask

    initial begin
        int n;
        int t;
        int exp_g[6];
        exp_g = '{0, 1, 2, 3, 0, 1};
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) rq_exp[i] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_id", 32'(bus.out_id), 32'd0);
        chk("rst_clamp_cnt", 32'(clamp_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request from requester 1, two-cycle latency
        bus.req_data[1]  = 16'h4200;
        rq_exp[1]        = 16'h3C00;
        bus.req_valid[1] = 1'b1;
        @(posedge clk);
        #1 bus.req_valid[1] = 1'b0;
        chk("lat_k_out_valid", 32'(bus.out_valid), 32'd0);
        chk("lat_k_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk("lat_k1_out_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
        chk("single_clamp_cnt", 32'(clamp_cnt), 32'd1);
        drain();

        // Back-to-back sequence through one requester
        clr_cnt();
        send(2, 16'hC500, 16'hBC00);
        send(2, 16'h3800, 16'h3800);
        send(2, 16'h3C00, 16'h3C00);
        send(2, 16'h7E00, 16'h3C00);
        drain();
        chk("seq_clamp_cnt", 32'(clamp_cnt), 32'd3);

        // Round robin with all requesters active, from a fresh rr_ptr
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        gnt_log.delete();
        bus.req_data[0] = 16'h3555; rq_exp[0] = 16'h3555;
        bus.req_data[1] = 16'h4000; rq_exp[1] = 16'h3C00;
        bus.req_data[2] = 16'hBBFF; rq_exp[2] = 16'hBBFF;
        bus.req_data[3] = 16'hFC00; rq_exp[3] = 16'hBC00;
        bus.req_valid   = 4'hF;
        repeat (6) @(posedge clk);
        #1 bus.req_valid = '0;
        chk("rr_grant_count", 32'(gnt_log.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < gnt_log.size()) chk("rr_grant_order", 32'(gnt_log[i]), 32'(exp_g[i]));
        drain();

        // Backpressure: two accepts into an empty pipe, then ready drops
        gnt_log.delete();
        bus.out_ready = 1'b0;
        bus.req_valid = 4'hF;
        repeat (6) @(posedge clk);
        #1;
        chk("bp_accepts", 32'(gnt_log.size()), 32'd2);
        chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
        if (gnt_log.size() >= 2) begin
            chk("bp_grant0", 32'(gnt_log[0]), 32'd2);
            chk("bp_grant1", 32'(gnt_log[1]), 32'd3);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume_grant", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1 bus.req_valid = '0;
        drain();

        // Async reset with both stages full
        bus.out_ready = 1'b0;
        bus.req_valid = 4'hF;
        repeat (2) @(posedge clk);
        #1 bus.req_valid = '0;
        chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        gnt_log.delete();
        bus.req_valid = 4'hF;
        @(posedge clk);
        #1 bus.req_valid = '0;
        chk("post_rst_grant_cnt", 32'(gnt_log.size()), 32'd1);
        if (gnt_log.size() >= 1) chk("post_rst_grant", 32'(gnt_log[0]), 32'd0);
        drain();

        // Counter saturation: preload 65534 clamped results
        clr_cnt();
        bus.req_data[0]  = 16'h7C00;
        rq_exp[0]        = 16'h3C00;
        bus.req_valid[0] = 1'b1;
        n = 0;
        t = 0;
        while (n < 65534 && t < 70000) begin
            @(negedge clk);
            t++;
            if (bus.req_ready[0]) n++;
        end
        @(posedge clk);
        #1 bus.req_valid[0] = 1'b0;
        chk("preload_count", 32'(n), 32'd65534);
        drain();
        chk("preload_clamp_cnt", 32'(clamp_cnt), 32'hFFFE);
        send(1, 16'hFC00, 16'hBC00);
        send(1, 16'hFC00, 16'hBC00);
        send(1, 16'hFC00, 16'hBC00);
        drain();
        chk("sat_clamp_cnt", 32'(clamp_cnt), 32'hFFFF);

        // Clear in the same cycle as a clamped delivery
        bus.out_ready = 1'b0;
        send(2, 16'h5000, 16'h3C00);
        @(posedge clk);
        #1;
        chk("clr_race_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        cnt_clr       = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        chk("clr_priority", 32'(clamp_cnt), 32'd0);
        drain();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
